// File: rtl/prm_pkg.sv
// Shared constants and state encoding for the PRM edge-mask packer.
package prm_pkg;

    localparam int unsigned DEF_OBS_W      = 15;
    localparam int unsigned DEF_NUM_EDGES  = 1024;
    localparam int unsigned DEF_WORD_W     = 32;
    localparam int unsigned DEF_SETTLE_CYC = 2;

    localparam int unsigned DEF_NUM_WORDS  = DEF_NUM_EDGES / DEF_WORD_W;
    localparam int unsigned DEF_IDX_W      = (DEF_NUM_WORDS > 1) ? $clog2(DEF_NUM_WORDS) : 1;
    localparam int unsigned DEF_CNT_W      = $clog2(DEF_NUM_EDGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_STREAM  = 2'd3
    } prm_state_e;

endpackage

// File: rtl/prm_popcount.sv
// Combinational set-bit counter for one packed output word.
module prm_popcount #(
    parameter  int unsigned WORD_W = 32,
    localparam int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic [WORD_W-1:0] i_data,
    output logic [CNT_W-1:0]  o_cnt
);

    // Sum of all bits; synthesis balances this into an adder tree.
    always_comb begin
        o_cnt = '0;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            o_cnt = o_cnt + CNT_W'(i_data[i]);
        end
    end

endmodule

// File: rtl/prm_edge_mask_packer.sv
// Registers an obstacle code for the checker array, waits for the checkers
// to settle, snapshots the edge mask and streams it out as packed words
// while counting blocked edges.
module prm_edge_mask_packer
    import prm_pkg::*;
#(
    parameter  int unsigned NUM_EDGES  = DEF_NUM_EDGES,
    parameter  int unsigned WORD_W     = DEF_WORD_W,
    parameter  int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter  int unsigned OBS_W      = DEF_OBS_W,
    localparam int unsigned NUM_WORDS  = NUM_EDGES / WORD_W,
    localparam int unsigned IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int unsigned CNT_W      = $clog2(NUM_EDGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 obs_valid,
    output logic                 obs_ready,
    input  logic [OBS_W-1:0]     obs_code,
    output logic [OBS_W-1:0]     chk_code,
    input  logic [NUM_EDGES-1:0] edge_mask_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
    output logic [CNT_W-1:0]     blocked_cnt,
    output logic                 scan_done
);

    localparam int unsigned PC_W = $clog2(WORD_W + 1);
    localparam int unsigned SC_W = $clog2(SETTLE_CYC + 1);

    prm_state_e           r_state;
    logic [OBS_W-1:0]     r_chk_code;
    logic                 r_obs_ready;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_scan_done;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [SC_W-1:0]      r_settle;
    logic [NUM_EDGES-1:0] r_snap;

    logic [WORD_W-1:0]    w_out_data;
    logic [PC_W-1:0]      w_pop;
    logic                 w_fire;

    // Word mux straight from the snapshot: stable for as long as r_idx holds.
    assign w_out_data = r_snap[r_idx * WORD_W +: WORD_W];
    assign w_fire     = r_out_valid & out_ready;

    prm_popcount #(
        .WORD_W (WORD_W)
    ) u_popcount (
        .i_data (w_out_data),
        .o_cnt  (w_pop)
    );

    // Scan sequencer: accept code, settle, capture, stream words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_chk_code  <= '0;
            r_obs_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_scan_done <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_settle    <= '0;
            r_snap      <= '0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (obs_valid && r_obs_ready) begin
                        r_chk_code  <= obs_code;
                        r_cnt       <= '0;
                        r_settle    <= SC_W'(SETTLE_CYC - 1);
                        r_obs_ready <= 1'b0;
                        r_state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == '0) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_snap      <= edge_mask_vec;
                    r_idx       <= '0;
                    r_out_last  <= (NUM_WORDS == 1);
                    r_out_valid <= 1'b1;
                    r_state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_fire) begin
                        r_cnt <= r_cnt + CNT_W'(w_pop);
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_scan_done <= 1'b1;
                            r_obs_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_out_last <= (r_idx == IDX_W'(NUM_WORDS - 2));
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign obs_ready   = r_obs_ready;
    assign chk_code    = r_chk_code;
    assign out_valid   = r_out_valid;
    assign out_data    = w_out_data;
    assign out_idx     = r_idx;
    assign out_last    = r_out_last;
    assign blocked_cnt = r_cnt;
    assign scan_done   = r_scan_done;

endmodule

// File: tb/tb_prm_edge_mask_packer.sv
// Directed bench for prm_edge_mask_packer at default parameters.
module tb_prm_edge_mask_packer;

    logic          clk;
    logic          rst;
    logic          obs_valid;
    logic          obs_ready;
    logic [14:0]   obs_code;
    logic [14:0]   chk_code;
    logic [1023:0] edge_mask_vec;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [4:0]    out_idx;
    logic          out_last;
    logic [10:0]   blocked_cnt;
    logic          scan_done;

    int n_checks;
    int n_fail;

    logic [1023:0] m_zero;
    logic [1023:0] m_ones;
    logic [1023:0] m_three;

    prm_edge_mask_packer #(
        .NUM_EDGES  (1024),
        .WORD_W     (32),
        .SETTLE_CYC (2),
        .OBS_W      (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .obs_valid     (obs_valid),
        .obs_ready     (obs_ready),
        .obs_code      (obs_code),
        .chk_code      (chk_code),
        .edge_mask_vec (edge_mask_vec),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_idx       (out_idx),
        .out_last      (out_last),
        .blocked_cnt   (blocked_cnt),
        .scan_done     (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_ready"}, obs_ready, 1'b1);
        check({tag, "_code"},  chk_code, 15'h0);
        check({tag, "_data"},  out_data, 32'h0);
        check({tag, "_idx"},   out_idx, 5'd0);
        check({tag, "_last"},  out_last, 1'b0);
        check({tag, "_cnt"},   blocked_cnt, 11'd0);
        check({tag, "_done"},  scan_done, 1'b0);
    endtask

    // One full scan; called with time at posedge+1 in an IDLE cycle.
    task automatic scan(input logic [14:0] code, input logic [1023:0] mask,
                        input bit bp, input bit force_zero, input bit hold_new,
                        input int abort_at, input logic [31:0] exp_w0, input int exp_cnt);
        int lat;
        int w;
        int cyc;
        bit rdy;
        edge_mask_vec = mask;
        check("accept_ready", obs_ready, 1'b1);
        obs_valid = 1'b1;
        obs_code  = code;
        @(posedge clk); #1;
        if (hold_new) obs_code = 15'h0001;
        else          obs_valid = 1'b0;
        check("chk_code", chk_code, code);
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (hold_new) begin
                check("hold_ready_settle", obs_ready, 1'b0);
                check("hold_code_settle", chk_code, code);
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 4);
        w   = 0;
        cyc = 0;
        while (w < 32 && cyc < 400) begin
            rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            out_ready = rdy;
            if (abort_at >= 0 && w == abort_at) begin
                check("abort_idx", out_idx, abort_at);
                rst = 1'b1;
                #1;
                check_reset_outputs("midrst");
                out_ready = 1'b0;
                #2 rst = 1'b0;
                @(posedge clk); #1;
                check("midrst_no_done", scan_done, 1'b0);
                check("midrst_idle_valid", out_valid, 1'b0);
                return;
            end
            check("out_valid", out_valid, 1'b1);
            check("out_idx", out_idx, w);
            check("out_data", out_data, mask[w*32 +: 32]);
            check("out_last", out_last, (w == 31));
            if (w == 0) check("word0", out_data, exp_w0);
            if (hold_new) begin
                check("hold_ready_stream", obs_ready, 1'b0);
                check("hold_code_stream", chk_code, code);
            end
            if (force_zero && cyc == 2) edge_mask_vec = '0;
            @(posedge clk); #1;
            if (rdy) w++;
            cyc++;
        end
        out_ready = 1'b0;
        check("scan_len", w, 32);
        check("scan_done", scan_done, 1'b1);
        check("done_valid", out_valid, 1'b0);
        check("done_cnt", blocked_cnt, exp_cnt);
        check("done_ready", obs_ready, 1'b1);
    endtask

    task automatic idle_hold(input int exp_cnt);
        @(posedge clk); #1;
        check("done_pulse_off", scan_done, 1'b0);
        @(posedge clk); #1;
        check("cnt_hold", blocked_cnt, exp_cnt);
        check("code_hold_idle", obs_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_zero   = '0;
        m_ones   = '1;
        for (int e = 0; e < 1024; e++) m_three[e] = (e % 3 == 0);

        rst           = 1'b1;
        obs_valid     = 1'b0;
        obs_code      = '0;
        out_ready     = 1'b0;
        edge_mask_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        scan(15'h4A21, m_zero, 1'b0, 1'b0, 1'b0, -1, 32'h0, 0);
        idle_hold(0);

        scan(15'h1234, m_three, 1'b0, 1'b0, 1'b0, -1, 32'h49249249, 342);
        idle_hold(342);

        scan(15'h1234, m_three, 1'b1, 1'b0, 1'b0, -1, 32'h49249249, 342);
        idle_hold(342);

        scan(15'h3F0F, m_ones, 1'b0, 1'b1, 1'b0, -1, 32'hFFFFFFFF, 1024);
        idle_hold(1024);

        scan(15'h5555, m_zero, 1'b0, 1'b0, 1'b1, -1, 32'h0, 0);
        scan(15'h0001, m_three, 1'b0, 1'b0, 1'b0, -1, 32'h49249249, 342);
        idle_hold(342);

        scan(15'h7FFF, m_three, 1'b0, 1'b0, 1'b0, 10, 32'h49249249, 342);
        scan(15'h2222, m_three, 1'b0, 1'b0, 1'b0, -1, 32'h49249249, 342);
        idle_hold(342);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prm_edge_mask_packer.md
Name: prm_edge_mask_packer

Overview:
- Sits directly downstream of the PRM edge obstacle-check array (one combinational checker per roadmap edge, all sharing the 15-bit obstacle code A..O).
- Accepts an obstacle code over a valid/ready handshake and registers it to drive the checker array.
- Waits for the checker logic to settle, then snapshots all edge_mask bits and streams them out as packed words to the path planner.
- Also accumulates a count of blocked edges.

Parameters:
- NUM_EDGES, 1024, number of roadmap edges / checker outputs; must be a multiple of WORD_W.
- WORD_W, 32, output word width.
- SETTLE_CYC, 2, cycles to wait after the code register updates before snapshot; minimum 1.
- OBS_W, 15, obstacle code width (checker inputs A..O; bit 0 = A, bit 14 = O).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- obs_valid  in  1  new obstacle code offered.
- obs_ready  out  1  block can accept a code; high only in IDLE.
- obs_code  in  OBS_W  obstacle code.
- chk_code  out  OBS_W  registered code driving all checker inputs.
- edge_mask_vec  in  NUM_EDGES  checker outputs; bit e = edge e blocked.
- out_valid  out  1  packed word available.
- out_ready  in  1  consumer accepts word.
- out_data  out  WORD_W  edge_mask bits [idx*WORD_W +: WORD_W].
- out_idx  out  clog2(NUM_EDGES/WORD_W)  word index.
- out_last  out  1  current word is the final word.
- blocked_cnt  out  clog2(NUM_EDGES+1)  running count of blocked edges in this scan.
- scan_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values (async on rst=1):
  - state=IDLE.
  - chk_code=0, out_valid=0, out_data=0, out_idx=0, out_last=0.
  - blocked_cnt=0, scan_done=0, obs_ready=1, settle counter=0, snapshot register=0.
- States are IDLE, SETTLE, CAPTURE and STREAM.
- IDLE:
  - obs_ready=1.
  - On obs_valid&obs_ready:
    - chk_code<=obs_code.
    - blocked_cnt<=0.
    - settle counter<=SETTLE_CYC-1.
    - Go to SETTLE.
- SETTLE:
  - obs_ready=0.
  - Counter decrements each cycle; at 0 go to CAPTURE.
  - Total SETTLE dwell is exactly SETTLE_CYC cycles.
- CAPTURE (1 cycle):
  - Snapshot register<=edge_mask_vec.
  - out_idx<=0.
  - Go to STREAM.
- STREAM:
  - out_valid=1.
  - out_data = snapshot word out_idx (registered or direct mux from the snapshot; either way stable while out_valid&!out_ready).
  - out_last = (out_idx == NUM_EDGES/WORD_W-1).
  - On out_valid&out_ready:
    - blocked_cnt += popcount(out_data).
    - If out_last: out_valid<=0, scan_done<=1 next cycle, go to IDLE.
    - Else: out_idx+1.
- Backpressure: out_ready may stay low indefinitely; out_data, out_idx and out_last must not change until accepted.
- Latency from code accept to first out_valid: SETTLE_CYC+2 cycles (e.g. 4 at default). Minimum scan with out_ready held high: SETTLE_CYC+1+NUM_EDGES/WORD_W cycles after accept.
- Arithmetic and widths:
  - blocked_cnt is unsigned and cannot overflow; its width holds NUM_EDGES.
  - Popcount is a WORD_W-bit adder tree, combinational, computed from out_data.
- blocked_cnt holds its final value in IDLE until the next code is accepted.
- The snapshot is immune to edge_mask_vec changes after CAPTURE.
- chk_code changes only on accept in IDLE, so the checker array is stable through CAPTURE.
- obs_valid while not IDLE: ignored, no state change; the offering side must hold the code.
- A code offered in the same cycle scan_done pulses is accepted (the block is already in IDLE that cycle).
- rst mid-scan: everything returns to reset values immediately, the partial scan is discarded, and there is no scan_done pulse.

Decomposition:
- Shared package prm_pkg holds:
  - OBS_W.
  - NUM_EDGES and WORD_W defaults.
  - The derived NUM_WORDS and index/count widths.
  - State enum (IDLE, SETTLE, CAPTURE, STREAM).
- One sub-module: prm_popcount (parameter WORD_W, purely combinational count of set bits), reused by the verification reference model.

Test Plan:
- Reset, then obs_code=15'h4A21 accepted, edge_mask_vec all zero, out_ready=1 -> chk_code=15'h4A21:
  - first out_valid 4 cycles after accept.
  - 32 words all 0, out_idx 0..31, out_last only on word 31.
  - scan_done 1 cycle after word 31 is accepted, blocked_cnt=0.
- edge_mask_vec = bit e set iff e%3==0, out_ready=1 -> word0=32'h49249249, blocked_cnt=342 at scan_done.
- Backpressure: out_ready toggled 1,0,0,1 in a repeating pattern -> no word skipped or duplicated, data stable while stalled, final blocked_cnt identical to the unstalled run.
- edge_mask_vec all ones, then forced to zero two cycles into STREAM -> all 32 words still 32'hFFFFFFFF, blocked_cnt=1024.
- obs_valid held high with a new code 15'h0001 during SETTLE and STREAM -> obs_ready=0 and chk_code unchanged; code accepted in the scan_done cycle, new scan starts.
- rst asserted at out_idx=10 -> outputs at reset values the same cycle, no scan_done; the next accept runs a full 32-word scan from idx 0.
